scale_factor_adapt: RTL and testbench

Quantizer scale-factor adaptation stage of the G.726 ADPCM encoder/decoder. It holds the unlocked (YU) and locked (YL) scale-factor state, mixes them into the quantizer scale factor Y, filters the log-domain multiplier WI into YUP (FILTD + LIMB), and hands YUP and YL to the downstream FILTE stage. It commits FILTE's returned YLP once per sample. It sits between the WI/AL producers and FILTE, and owns the only YU/YL delay registers in the datapath.

---
 rtl/scale_factor_adapt_pkg.sv | 14 +
 rtl/scale_factor_adapt_if.sv | 24 ++
 rtl/scale_factor_adapt_limb.sv | 18 +
 rtl/scale_factor_adapt.sv | 109 ++++++++++
 tb/tb_scale_factor_adapt.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/scale_factor_adapt_pkg.sv
// rtl/scale_factor_adapt_pkg.sv - shared constants and FSM state type for the scale-factor adaptation stage
package sfa_pkg;

    localparam logic [12:0] YU_MIN   = 13'd544;
    localparam logic [12:0] YU_MAX   = 13'd5120;
    localparam logic [12:0] YU_RESET = 13'd544;
    localparam logic [18:0] YL_RESET = 19'd34816;

    typedef enum logic {
        IDLE = 1'b0,
        FILT = 1'b1
    } state_t;

endpackage

// File: rtl/scale_factor_adapt_if.sv
// rtl/scale_factor_adapt_if.sv - update handshake and FILTE exchange bundle for scale_factor_adapt
interface scale_factor_adapt_if;

    logic [6:0]  AL;
    logic [11:0] WI;
    logic        upd_valid;
    logic        upd_ready;
    logic [12:0] Y;
    logic [12:0] YUP;
    logic [18:0] YL;
    logic [18:0] YLP;
    logic        done;

    modport master (
        output AL, WI, upd_valid, YLP,
        input  upd_ready, Y, YUP, YL, done
    );

    modport slave (
        input  AL, WI, upd_valid, YLP,
        output upd_ready, Y, YUP, YL, done
    );

endinterface

// File: rtl/scale_factor_adapt_limb.sv
// rtl/scale_factor_adapt_limb.sv - unsigned clamp of the unlocked scale factor into [YU_MIN, YU_MAX]
module limb
    import sfa_pkg::*;
(
    input  logic [12:0] yut,
    output logic [12:0] yup
);

    always_comb begin
        yup = yut;
        if (yut < YU_MIN) begin
            yup = YU_MIN;
        end else if (yut > YU_MAX) begin
            yup = YU_MAX;
        end
    end

endmodule

// File: rtl/scale_factor_adapt.sv
// rtl/scale_factor_adapt.sv - G.726 scale-factor adaptation (MIX, FILTD, LIMB, YU/YL state); optional homing via FILT_HOMING_EN
module scale_factor_adapt
    import sfa_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
`ifdef FILT_HOMING_EN
    input  logic                 home,
`endif
    scale_factor_adapt_if.slave  bus
);

    state_t      state;
    logic [12:0] yu_r;
    logic [18:0] yl_r;
    logic [12:0] yup_r;
    logic        ready_r;
    logic        done_r;

    // MIX: blend unlocked and locked factors by speed control AL
    logic [12:0] yls;
    logic [13:0] dif;
    logic        difs;
    logic [12:0] difm;
    logic [19:0] prod_full;
    logic [13:0] prodm;
    logic [13:0] prod;
    logic [12:0] y;

    assign yls       = yl_r[18:6];
    assign dif       = {1'b0, yu_r} - {1'b0, yls};
    assign difs      = dif[13];
    assign difm      = difs ? 13'(14'd0 - dif) : dif[12:0];
    assign prod_full = {7'd0, difm} * {13'd0, bus.AL};
    assign prodm     = 14'(prod_full >> 6);
    assign prod      = difs ? (14'd0 - prodm) : prodm;
    assign y         = 13'({1'b0, yls} + prod);

    // FILTD: sign-extended (WI - Y) >> 5 folded into a 13-bit increment
    logic [16:0] d;
    logic        ds;
    logic [12:0] dx;
    logic [12:0] yut;
    logic [12:0] yup_next;

    assign d   = {bus.WI, 5'd0} - {4'd0, y};
    assign ds  = d[16];
    assign dx  = 13'(d >> 5) + (ds ? 13'd4096 : 13'd0);
    assign yut = y + dx;

    limb u_limb (
        .yut (yut),
        .yup (yup_next)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            yu_r    <= YU_RESET;
            yl_r    <= YL_RESET;
            yup_r   <= YU_RESET;
            ready_r <= 1'b1;
            done_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
`ifdef FILT_HOMING_EN
                    if (home) begin
                        yu_r  <= YU_RESET;
                        yl_r  <= YL_RESET;
                        yup_r <= YU_RESET;
                    end else if (bus.upd_valid) begin
                        yup_r   <= yup_next;
                        ready_r <= 1'b0;
                        state   <= FILT;
                    end
`else
                    if (bus.upd_valid) begin
                        yup_r   <= yup_next;
                        ready_r <= 1'b0;
                        state   <= FILT;
                    end
`endif
                end
                FILT: begin
                    // FILTE has had the whole cycle to settle on YUP/YL
                    yu_r    <= yup_r;
                    yl_r    <= bus.YLP;
                    done_r  <= 1'b1;
                    ready_r <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    ready_r <= 1'b1;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Y         = y;
    assign bus.YUP       = yup_r;
    assign bus.YL        = yl_r;
    assign bus.upd_ready = ready_r;
    assign bus.done      = done_r;

endmodule

// File: tb/tb_scale_factor_adapt.sv
// tb/tb_scale_factor_adapt.sv - directed self-checking bench for scale_factor_adapt (homing tests under FILT_HOMING_EN)
module tb_scale_factor_adapt;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
`ifdef FILT_HOMING_EN
    logic home = 1'b0;
`endif
    int n_cmp = 0;
    int n_bad = 0;

    scale_factor_adapt_if sfa ();

    scale_factor_adapt dut (
        .clk     (clk),
        .reset_n (reset_n),
`ifdef FILT_HOMING_EN
        .home    (home),
`endif
        .bus     (sfa)
    );

    logic [12:0] ref_yut;
    logic [12:0] ref_yup;

    limb u_ref (
        .yut (ref_yut),
        .yup (ref_yup)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        sfa.upd_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic update(input string tag, input logic [11:0] wi, input logic [18:0] ylp,
                          input logic [12:0] exp_yup);
        int n;
        n = 0;
        @(negedge clk);
        while (!sfa.upd_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready_wait"}, 32'(sfa.upd_ready), 32'd1);
        sfa.WI = wi;
        sfa.YLP = ylp;
        sfa.upd_valid = 1'b1;
        @(posedge clk);
        #1;
        sfa.upd_valid = 1'b0;
        check({tag, "_yup"}, 32'(sfa.YUP), 32'(exp_yup));
        check({tag, "_busy"}, 32'(sfa.upd_ready), 32'd0);
        check({tag, "_done_early"}, 32'(sfa.done), 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_done"}, 32'(sfa.done), 32'd1);
        check({tag, "_yl"}, 32'(sfa.YL), 32'(ylp));
        @(posedge clk);
        #1;
        check({tag, "_done_fall"}, 32'(sfa.done), 32'd0);
    endtask

    initial begin
        int acc;
        int dn;
        sfa.AL = 7'd0;
        sfa.WI = 12'd0;
        sfa.upd_valid = 1'b0;
        sfa.YLP = 19'd34816;

        // clamp helper against hand values
        ref_yut = 13'd0;    #1 check("limb_0", 32'(ref_yup), 32'd544);
        ref_yut = 13'd543;  #1 check("limb_543", 32'(ref_yup), 32'd544);
        ref_yut = 13'd3000; #1 check("limb_3000", 32'(ref_yup), 32'd3000);
        ref_yut = 13'd5121; #1 check("limb_5121", 32'(ref_yup), 32'd5120);

        repeat (2) @(negedge clk);
        #1;
        check("rst_y", 32'(sfa.Y), 32'd544);
        check("rst_yup", 32'(sfa.YUP), 32'd544);
        check("rst_yl", 32'(sfa.YL), 32'd34816);
        check("rst_ready", 32'(sfa.upd_ready), 32'd1);
        check("rst_done", 32'(sfa.done), 32'd0);
        reset_n = 1'b1;

        // WI=0: YUT=527 clamped to 544; FILTE returns a distinct YLP
        update("wi0", 12'h000, 19'd34916, 13'd544);
        check("wi0_y", 32'(sfa.Y), 32'd545);

        apply_reset();
        update("wi462", 12'h462, 19'd34816, 13'd1649);
        sfa.AL = 7'd64; #1 check("al64_y", 32'(sfa.Y), 32'd1649);
        sfa.AL = 7'd32; #1 check("al32_y", 32'(sfa.Y), 32'd1096);
        check("al_state_yup", 32'(sfa.YUP), 32'd1649);

        // drive YU and YL>>6 to 5120, then hit the upper clamp
        sfa.AL = 7'd0;
        update("lift_yl", 12'h462, 19'd327680, 13'd1649);
        check("lift_y", 32'(sfa.Y), 32'd5120);
        update("lift_yu", 12'h7ff, 19'd327680, 13'd5120);
        sfa.AL = 7'd64;
        #1 check("hi_y", 32'(sfa.Y), 32'd5120);
        update("hi_clamp", 12'h462, 19'd327680, 13'd5120);

        // back-to-back requests
        apply_reset();
        sfa.AL = 7'd0;
        sfa.WI = 12'h000;
        sfa.YLP = 19'd34816;
        acc = 0;
        dn = 0;
        @(negedge clk);
        sfa.upd_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("tp_ready_%0d", i), 32'(sfa.upd_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
            if (sfa.upd_valid && sfa.upd_ready) acc++;
            if (sfa.done) dn++;
            @(negedge clk);
        end
        sfa.upd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (sfa.done) dn++;
            @(negedge clk);
        end
        check("tp_accepts", 32'(acc), 32'd3);
        check("tp_dones", 32'(dn), 32'd3);

        // reset in FILT discards the commit
        apply_reset();
        @(negedge clk);
        sfa.WI = 12'h462;
        sfa.YLP = 19'd99999;
        sfa.upd_valid = 1'b1;
        @(posedge clk);
        #1;
        sfa.upd_valid = 1'b0;
        check("rf_in_filt", 32'(sfa.upd_ready), 32'd0);
        #2 reset_n = 1'b0;
        #1;
        check("rf_yup", 32'(sfa.YUP), 32'd544);
        check("rf_ready", 32'(sfa.upd_ready), 32'd1);
        @(posedge clk);
        #1;
        check("rf_done", 32'(sfa.done), 32'd0);
        check("rf_yl", 32'(sfa.YL), 32'd34816);
        check("rf_y", 32'(sfa.Y), 32'd544);
        @(negedge clk);
        reset_n = 1'b1;

`ifdef FILT_HOMING_EN
        update("pre_home", 12'h462, 19'd40000, 13'd1649);
        @(negedge clk);
        home = 1'b1;
        sfa.WI = 12'h462;
        sfa.upd_valid = 1'b1;
        @(posedge clk);
        #1;
        home = 1'b0;
        sfa.upd_valid = 1'b0;
        check("home_yup", 32'(sfa.YUP), 32'd544);
        check("home_yl", 32'(sfa.YL), 32'd34816);
        check("home_ready", 32'(sfa.upd_ready), 32'd1);
        check("home_y", 32'(sfa.Y), 32'd544);
        @(posedge clk);
        #1;
        check("home_done", 32'(sfa.done), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
